// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, constants and record types for the fetch stage
// Purpose: common definitions imported by fetch_unit and its helpers.
//   INSTR_W / ADDR_W : instruction and address widths
//   RESET_PC_DEF     : default program counter after reset
//   PC_STEP          : sequential fetch increment
//   pend_t           : in-flight request record {epoch, pc}
//   iq_ent_t         : buffered instruction record {instr, pc}
package cpu_pkg;

   localparam int INSTR_W = 32;
   localparam int ADDR_W  = 32;

   localparam logic [ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
   localparam logic [ADDR_W-1:0] PC_STEP      = 32'd4;

   typedef struct packed {
      logic              epoch;
      logic [ADDR_W-1:0] pc;
   } pend_t;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } iq_ent_t;

   // Redirect targets are forced onto a word boundary.
   function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
      return a & ~ADDR_W'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - parameterised synchronous FIFO with clear and occupancy count
// Purpose: small register FIFO used for the pending-request tracker and the
// instruction queue. DEPTH must be a power of two so pointers wrap naturally.
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_clear          : synchronous flush (dominates push/pop)
//   i_push, i_wdata  : write side; ignored when full unless popping the same cycle
//   i_pop            : read side; ignored when empty
//   o_rdata          : head entry (undefined when empty)
//   o_full, o_empty  : status flags
//   o_count          : number of stored entries
module fetch_fifo #(
   parameter  int W     = 32,
   parameter  int DEPTH = 2,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clear,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty,
   output logic [AW:0]  o_count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);
   assign o_rdata   = r_mem[r_rptr];
   assign o_count   = r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else if (i_clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wptr <= r_wptr + AW'(1);
         if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      end
   end

   // Storage needs no reset: entries are only read once counted as valid.
   always_ff @(posedge i_clk) begin
      if (w_do_push && !i_clear) r_mem[r_wptr] <= i_wdata;
   end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage driving the PC register's next-PC input
// Purpose: issues in-order fetches at pc_in, tracks in-flight requests, buffers
// returned words for decode and flushes on redirect using an epoch bit.
// Ports:
//   clk, rst                         : clock, asynchronous active-low reset
//   pc_in / npc                      : current PC in, next PC out (combinational)
//   imem_req_valid/ready/addr        : fetch request channel
//   imem_rsp_valid/data              : in-order response channel (no back-pressure)
//   redirect_valid/pc                : taken branch/jump target
//   id_valid/ready, id_instr/pc/pc4  : decode-side handshake and payload
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF,
   parameter int                QDEPTH   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc_in,
   output logic [ADDR_W-1:0]  npc,
   output logic               imem_req_valid,
   input  logic               imem_req_ready,
   output logic [ADDR_W-1:0]  imem_req_addr,
   input  logic               imem_rsp_valid,
   input  logic [INSTR_W-1:0] imem_rsp_data,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               id_valid,
   input  logic               id_ready,
   output logic [INSTR_W-1:0] id_instr,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [ADDR_W-1:0]  id_pc4
);

   localparam int              CW      = $clog2(QDEPTH) + 1;
   localparam logic [CW:0]     OCC_MAX = (CW+1)'(QDEPTH);

   logic          r_epoch;

   logic          w_pend_push;
   logic          w_pend_pop;
   logic          w_pend_full;
   logic          w_pend_empty;
   logic [CW-1:0] w_inflight;
   pend_t         w_pend_wdata;
   pend_t         w_pend_head;

   logic          w_iq_push;
   logic          w_iq_pop;
   logic          w_iq_full;
   logic          w_iq_empty;
   logic [CW-1:0] w_count;
   iq_ent_t       w_iq_wdata;
   iq_ent_t       w_iq_head;

   logic [CW:0]   w_occ;
   logic          w_credit;
   logic          w_req_fire;

   // Stale in-flight entries keep consuming credit until their response drains.
   assign w_occ      = {1'b0, w_inflight} + {1'b0, w_count};
   assign w_credit   = (w_occ < OCC_MAX);

   assign imem_req_valid = w_credit & ~redirect_valid & rst;
   assign imem_req_addr  = pc_in;
   assign w_req_fire     = imem_req_valid & imem_req_ready;

   // The PC register has no enable, so "hold" means feeding pc_in back.
   always_comb begin
      npc = pc_in;
      if (!rst)                npc = RESET_PC;
      else if (redirect_valid) npc = align_pc(redirect_pc);
      else if (w_req_fire)     npc = pc_in + PC_STEP;
   end

   assign w_pend_push  = w_req_fire;
   assign w_pend_wdata = '{epoch: r_epoch, pc: pc_in};
   assign w_pend_pop   = imem_rsp_valid;

   // A response is kept only if issued in the current epoch and no redirect
   // is flushing the queue this very cycle.
   assign w_iq_push  = imem_rsp_valid & ~w_pend_empty &
                       (w_pend_head.epoch == r_epoch) & ~redirect_valid;
   assign w_iq_wdata = '{instr: imem_rsp_data, pc: w_pend_head.pc};
   assign w_iq_pop   = id_valid & id_ready & ~redirect_valid;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                r_epoch <= 1'b0;
      else if (redirect_valid) r_epoch <= ~r_epoch;
   end

   fetch_fifo #(.W($bits(pend_t)), .DEPTH(QDEPTH)) u_pend (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_clear (1'b0),
      .i_push  (w_pend_push),
      .i_wdata (w_pend_wdata),
      .i_pop   (w_pend_pop),
      .o_rdata (w_pend_head),
      .o_full  (w_pend_full),
      .o_empty (w_pend_empty),
      .o_count (w_inflight)
   );

   fetch_fifo #(.W($bits(iq_ent_t)), .DEPTH(QDEPTH)) u_iq (
      .i_clk   (clk),
      .i_rst_n (rst),
      .i_clear (redirect_valid),
      .i_push  (w_iq_push),
      .i_wdata (w_iq_wdata),
      .i_pop   (w_iq_pop),
      .o_rdata (w_iq_head),
      .o_full  (w_iq_full),
      .o_empty (w_iq_empty),
      .o_count (w_count)
   );

   // Payload is forced to zero whenever the queue is empty (including reset).
   assign id_valid = ~w_iq_empty;
   assign id_instr = id_valid ? w_iq_head.instr            : '0;
   assign id_pc    = id_valid ? w_iq_head.pc               : '0;
   assign id_pc4   = id_valid ? (w_iq_head.pc + PC_STEP)   : '0;

   a_rsp_tracked : assert property (@(posedge clk) disable iff (!rst)
      imem_rsp_valid |-> !w_pend_empty);
   a_pend_no_ovf : assert property (@(posedge clk) disable iff (!rst)
      w_pend_push |-> !w_pend_full);
   a_iq_no_ovf   : assert property (@(posedge clk) disable iff (!rst)
      w_iq_push |-> !w_iq_full);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_in;
   logic [31:0] npc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;

   fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .pc_in          (pc_in),
      .npc            (npc),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc4         (id_pc4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [31:0] pc;
      logic        rdy;
      logic        rv;
      logic [31:0] rdpc;
      logic        redir;
      logic [31:0] rpc;
      logic        idr;
      logic [31:0] enpc;
      logic        ereq;
      logic        eidv;
      logic [31:0] eipc;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   vec_t  vt[$];
   mreq_t mq[$];
   int    n_vec = 0;
   int    n_err = 0;

   function automatic logic [31:0] instr_of(input logic [31:0] pc);
      return 32'hC0DE_0000 ^ pc;
   endfunction

   task automatic add(input logic r, input logic [31:0] pc, input logic rdy,
                      input logic rv, input logic [31:0] rdpc, input logic redir,
                      input logic [31:0] rpc, input logic idr, input logic [31:0] enpc,
                      input logic ereq, input logic eidv, input logic [31:0] eipc);
      vec_t v;
      v = '{r, pc, rdy, rv, rdpc, redir, rpc, idr, enpc, ereq, eidv, eipc};
      vt.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   initial begin
      logic [31:0] pcm;
      logic [31:0] expc;
      int          n_acc;
      int          n_cons;

      rst = 1'b0; pc_in = '0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
      imem_rsp_data = '0; redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;

      //   rst pc          rdy rv rdpc        rdr rpc          idr | npc          req idv ipc
      add(0, 32'h0,        0,  0, 32'h0,      0,  32'h0,       0,  32'h0,        0,  0,  32'h0);
      add(1, 32'h0,        1,  0, 32'h0,      0,  32'h0,       1,  32'h4,        1,  0,  32'h0);
      add(1, 32'h4,        1,  1, 32'h0,      0,  32'h0,       1,  32'h8,        1,  0,  32'h0);
      add(1, 32'h8,        1,  1, 32'h4,      0,  32'h0,       1,  32'h8,        0,  1,  32'h0);
      add(1, 32'h8,        1,  0, 32'h0,      0,  32'h0,       1,  32'hC,        1,  1,  32'h4);
      add(1, 32'hC,        1,  1, 32'h8,      0,  32'h0,       1,  32'h10,       1,  0,  32'h0);
      add(1, 32'h10,       1,  1, 32'hC,      0,  32'h0,       1,  32'h10,       0,  1,  32'h8);
      add(1, 32'h10,       1,  0, 32'h0,      0,  32'h0,       0,  32'h14,       1,  1,  32'hC);
      // redirect to 0x103 (aligned 0x100) with 0x10 still in flight
      add(1, 32'h14,       1,  0, 32'h0,      1,  32'h103,     1,  32'h100,      0,  1,  32'hC);
      add(1, 32'h100,      1,  1, 32'h10,     0,  32'h0,       1,  32'h104,      1,  0,  32'h0);
      add(1, 32'h104,      1,  1, 32'h100,    0,  32'h0,       1,  32'h108,      1,  0,  32'h0);
      add(1, 32'h108,      1,  0, 32'h0,      0,  32'h0,       1,  32'h108,      0,  1,  32'h100);
      add(1, 32'h108,      1,  1, 32'h104,    0,  32'h0,       1,  32'h10C,      1,  0,  32'h0);
      // redirect to the top of memory with a same-cycle response and id handshake
      add(1, 32'h10C,      1,  1, 32'h108,    1,  32'hFFFFFFFC,1,  32'hFFFFFFFC, 0,  1,  32'h104);
      add(1, 32'hFFFFFFFC, 1,  0, 32'h0,      0,  32'h0,       1,  32'h0,        1,  0,  32'h0);
      add(1, 32'h0,        1,  1, 32'hFFFFFFFC,0, 32'h0,       1,  32'h4,        1,  0,  32'h0);
      add(1, 32'h4,        1,  1, 32'h0,      0,  32'h0,       1,  32'h4,        0,  1,  32'hFFFFFFFC);
      add(1, 32'h4,        1,  0, 32'h0,      0,  32'h0,       1,  32'h8,        1,  1,  32'h0);
      add(1, 32'h8,        0,  1, 32'h4,      0,  32'h0,       0,  32'h8,        1,  0,  32'h0);
      // async reset with one queued entry, then a decode stall from the start
      add(0, 32'h0,        0,  0, 32'h0,      0,  32'h0,       0,  32'h0,        0,  0,  32'h0);
      add(1, 32'h0,        1,  0, 32'h0,      0,  32'h0,       0,  32'h4,        1,  0,  32'h0);
      add(1, 32'h4,        1,  1, 32'h0,      0,  32'h0,       0,  32'h8,        1,  0,  32'h0);
      add(1, 32'h8,        1,  1, 32'h4,      0,  32'h0,       0,  32'h8,        0,  1,  32'h0);
      add(1, 32'h8,        1,  0, 32'h0,      0,  32'h0,       0,  32'h8,        0,  1,  32'h0);
      add(1, 32'h8,        1,  0, 32'h0,      0,  32'h0,       1,  32'h8,        0,  1,  32'h0);
      add(1, 32'h8,        1,  0, 32'h0,      0,  32'h0,       1,  32'hC,        1,  1,  32'h4);
      add(1, 32'hC,        1,  1, 32'h8,      0,  32'h0,       1,  32'h10,       1,  0,  32'h0);
      add(1, 32'h10,       1,  0, 32'h0,      0,  32'h0,       1,  32'h10,       0,  1,  32'h8);

      for (int i = 0; i < vt.size(); i++) begin
         @(negedge clk);
         rst            = vt[i].rst;
         pc_in          = vt[i].pc;
         imem_req_ready = vt[i].rdy;
         imem_rsp_valid = vt[i].rv;
         imem_rsp_data  = vt[i].rv ? instr_of(vt[i].rdpc) : 32'h0;
         redirect_valid = vt[i].redir;
         redirect_pc    = vt[i].rpc;
         id_ready       = vt[i].idr;
         #1;
         chk($sformatf("v%0d_npc", i), npc, vt[i].enpc);
         chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].ereq));
         chk($sformatf("v%0d_id_valid", i), 32'(id_valid), 32'(vt[i].eidv));
         if (vt[i].eidv || !vt[i].rst) begin
            chk($sformatf("v%0d_id_pc", i), id_pc, vt[i].eipc);
            chk($sformatf("v%0d_id_pc4", i), id_pc4,
                vt[i].eidv ? vt[i].eipc + 32'd4 : 32'h0);
            chk($sformatf("v%0d_id_instr", i), id_instr,
                vt[i].eidv ? instr_of(vt[i].eipc) : 32'h0);
         end
         if (vt[i].ereq) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vt[i].pc);
      end

      // Random request back-pressure and decode stalls, 3-cycle memory latency.
      @(negedge clk);
      rst = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0;
      id_ready = 1'b0; pc_in = 32'h0;
      @(negedge clk);
      rst = 1'b1; pcm = 32'h0; expc = 32'h0; n_acc = 0; n_cons = 0;
      for (int c = 0; c < 300; c++) begin
         if (c > 0) @(negedge clk);
         pc_in          = pcm;
         imem_req_ready = ($urandom_range(0, 1) == 1);
         id_ready       = ($urandom_range(0, 3) != 0);
         if (mq.size() > 0 && mq[0].due == c) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = instr_of(mq[0].addr);
            void'(mq.pop_front());
         end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
         end
         #1;
         chk($sformatf("rnd%0d_occupancy_le2", c), 32'(n_acc - n_cons <= 2), 32'h1);
         if (id_valid && id_ready) begin
            chk($sformatf("rnd%0d_id_pc", c), id_pc, expc);
            chk($sformatf("rnd%0d_id_pc4", c), id_pc4, expc + 32'd4);
            chk($sformatf("rnd%0d_id_instr", c), id_instr, instr_of(expc));
            expc = expc + 32'd4;
            n_cons++;
         end
         if (imem_req_valid && imem_req_ready) begin
            chk($sformatf("rnd%0d_req_addr", c), imem_req_addr, pcm);
            mq.push_back('{pcm, c + 3});
            n_acc++;
         end
         pcm = npc;
      end
      chk("rnd_progress_ge30", 32'(n_cons >= 30), 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
